// File: rtl/mul_seq16.sv
// Sequential unsigned 16x16->32 shift-add multiplier built around one
// 16-bit carry-lookahead adder that is reused for every partial-product add.
// CLA16bit is the adder; mul_seq16 is the top-level multiplier.

// 16-bit carry-lookahead adder/subtractor: four 4-bit lookahead groups
// with a second lookahead level across the groups.
module CLA16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        SUB,
  output logic [15:0] SUM,
  output logic        Cout
);

  logic [15:0] b_eff_s;
  logic [15:0] p_s;
  logic [15:0] g_s;
  logic [3:0]  gp_s;
  logic [3:0]  gg_s;
  logic [4:0]  gc_s;
  logic [15:0] c_s;

  // Subtraction is A + ~B + 1; the +1 enters as the group-0 carry-in.
  assign b_eff_s = B ^ {16{SUB}};
  assign p_s     = A ^ b_eff_s;
  assign g_s     = A & b_eff_s;

  // Group propagate/generate for each 4-bit slice.
  always_comb begin
    gp_s = 4'h0;
    gg_s = 4'h0;
    for (int k = 0; k < 4; k++) begin
      gp_s[k] = &p_s[4*k +: 4];
      gg_s[k] = g_s[4*k+3]
              | (p_s[4*k+3] & g_s[4*k+2])
              | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
              | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
    end
  end

  // Second-level lookahead: carry into each group and the final carry out.
  always_comb begin
    gc_s    = 5'h00;
    gc_s[0] = SUB;
    gc_s[1] = gg_s[0] | (gp_s[0] & gc_s[0]);
    gc_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & gc_s[0]);
    gc_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
            | (gp_s[2] & gp_s[1] & gp_s[0] & gc_s[0]);
    gc_s[4] = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
            | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0])
            | (gp_s[3] & gp_s[2] & gp_s[1] & gp_s[0] & gc_s[0]);
  end

  // First-level lookahead: per-bit carries inside each group from its carry-in.
  always_comb begin
    c_s = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      c_s[4*k]   = gc_s[k];
      c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & gc_s[k]);
      c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+1] & p_s[4*k] & gc_s[k]);
      c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & gc_s[k]);
    end
  end

  assign SUM  = p_s ^ c_s;
  assign Cout = gc_s[4];

endmodule

// Shift-add multiplier. acc_lo starts out holding the multiplier; each RUN
// cycle conditionally adds the multiplicand into acc_hi and shifts the
// 33-bit {carry, sum, acc_lo} right by one, so after 16 iterations
// {acc_hi, acc_lo} is the full product. WIDTH must be 16 (the adder width).
module mul_seq16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;

  logic [WIDTH-1:0]   add_b_s;
  logic [WIDTH-1:0]   sum_s;
  logic               cout_s;

  // Partial product is the multiplicand when the current multiplier bit is 1.
  assign add_b_s = acc_lo_q[0] ? mcand_q : {WIDTH{1'b0}};

  CLA16bit u_add (
    .A    (acc_hi_q),
    .B    (add_b_s),
    .SUB  (1'b0),
    .SUM  (sum_s),
    .Cout (cout_s)
  );

  // State and datapath registers; reset clears everything and aborts a multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      acc_hi_q <= {WIDTH{1'b0}};
      acc_lo_q <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
    end
  end

  // Next-state and datapath update; registers hold unless the state says otherwise.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = a;
          acc_hi_d = {WIDTH{1'b0}};
          acc_lo_d = b;
          cnt_d    = {CNT_W{1'b0}};
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        // The adder carry becomes the new top bit; dropping it loses overflow.
        {acc_hi_d, acc_lo_d} = {cout_s, sum_s, acc_lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status decode from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        done = 1'b0;
      end
      ST_RUN: begin
        busy = 1'b1;
        done = 1'b0;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // The accumulator is frozen outside RUN, so the product holds after done.
  assign product = {acc_hi_q, acc_lo_q};

endmodule

// File: tb/tb_mul_seq16.sv
// Self-checking bench for mul_seq16: a cycle-level reference model of the
// handshake and a*b result, plus directed vectors with literal products.
module tb_mul_seq16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_total;
  int n_bad;

  // Reference model: number of busy cycles left after the latest edge and
  // the product the multiplier must present once it is done.
  int          m_left;
  logic [31:0] m_prod;
  bit          m_valid;

  mul_seq16 #(.WIDTH(16), .CNT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: a multiply occupies 17 busy cycles (16 RUN + 1 DONE).
  always @(posedge clk) begin
    if (rst) begin
      m_left  <= 0;
      m_prod  <= 32'h0;
      m_valid <= 1'b1;
    end else if (m_left > 0) begin
      m_left  <= m_left - 1;
    end else if (start) begin
      m_left  <= 17;
      m_prod  <= {16'h0, a} * {16'h0, b};
    end
  end

  // Compare process: handshake every cycle, product whenever it is meaningful.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", {31'h0, busy}, {31'h0, (m_left > 0)});
      chk("done", {31'h0, done}, {31'h0, (m_left == 1)});
      if (m_left <= 1) chk("product", product, m_prod);
    end
  end

  // One multiply from idle; returns on the done cycle with the product.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input bit use_lit, input logic [31:0] lit,
                        output logic [31:0] got);
    int n;
    int busy_n;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    n = 1;
    busy_n = busy ? 1 : 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
    end
    if (!done) begin
      chk("done_timeout", 32'h0, 32'h1);
      got = 32'h0;
    end else begin
      chk("latency_edges", 32'(n - 1), 32'd16);
      chk("busy_cycles", 32'(busy_n), 32'd17);
      if (use_lit) chk("lit_product", product, lit);
      got = product;
    end
  endtask

  initial begin
    logic [31:0] got;
    int cyc, last, ndone, nd;
    logic [15:0] ra, rb;

    n_total = 0; n_bad = 0;
    m_left = 0; m_prod = 32'h0; m_valid = 1'b0;

    // 1: reset held with start asserted; nothing may start.
    rst = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h1234;
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_product", product, 32'h0);
    end
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);

    // 2 and 3: directed products.
    run_op(16'd3, 16'd5, 1'b1, 32'h0000000F, got);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001, got);
    run_op(16'h0000, 16'hFFFF, 1'b1, 32'h00000000, got);
    run_op(16'h1234, 16'h0010, 1'b1, 32'h00012340, got);
    run_op(16'hFFFF, 16'h0001, 1'b1, 32'h0000FFFF, got);

    // 4: start held high; a/b scrambled while running must not matter.
    @(negedge clk);
    start = 1'b1; a = 16'h8000; b = 16'h0002;
    cyc = 0; last = -1; ndone = 0;
    while (ndone < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        chk("stream_product", product, 32'h00010000);
        if (last >= 0) chk("stream_period", 32'(cyc - last), 32'd18);
        last = cyc;
        ndone++;
      end
      if (busy && !done) begin
        a = 16'($urandom); b = 16'($urandom);
      end else begin
        a = 16'h8000; b = 16'h0002;
      end
    end
    chk("stream_count", 32'(ndone), 32'd3);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // 5: reset in the middle of RUN aborts without a done pulse.
    start = 1'b1; a = 16'h00AB; b = 16'h00CD;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_product", product, 32'h0);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    run_op(16'h00FF, 16'h0101, 1'b1, 32'h0000FFFF, got);

    // 6: random operands against a*b, then a stable hold with start low.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 0) ra = 16'hFFFF;
      run_op(ra, rb, 1'b1, {16'h0, ra} * {16'h0, rb}, got);
      repeat (5) begin
        @(negedge clk);
        chk("hold_product", product, got);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
